dac_spi_arbiter: RTL

// - Shares one DAC SPI master (spi_master_o) among N_REQ writers: Wishbone threshold write and the two ch_measure_ctl sweeps.
// - Each requester has a 1-deep coalescing slot; slots are served round-robin, one SPI frame at a time.
// - Reports per-requester done and busy status, plus a sticky error if the SPI master hangs.
// - Sits in measure_unit between the requesters and the wre_i/data_i/rdy_o pins of the SPI instance.

---
 rtl/dac_spi_arbiter_if.sv | 18 +
 rtl/dac_spi_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/dac_spi_arbiter_if.sv
// dac_spi_arbiter_if: requester strobes/status and SPI-master load handshake of the DAC SPI arbiter
interface dac_spi_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int CODE_W = 16,
  parameter int DATA_W = 24
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*CODE_W-1:0] code;
  logic [N_REQ-1:0]        done;
  logic [N_REQ-1:0]        busy;
  logic                    err;
  logic                    err_clr;
  logic [DATA_W-1:0]       spi_data;
  logic                    spi_wre;
  logic                    spi_rdy;
  modport master (output req, code, err_clr, spi_rdy, input done, busy, err, spi_data, spi_wre);
  modport slave  (input req, code, err_clr, spi_rdy, output done, busy, err, spi_data, spi_wre);
endinterface

// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter: round-robin sharing of one DAC SPI master among N_REQ 1-deep coalescing writers
// Define DAC_ARB_WB_PRIO_EN to give requester 0 absolute priority over the round-robin group.
module dac_spi_arbiter #(
  parameter int N_REQ          = 3,
  parameter int CODE_W         = 16,
  parameter int DATA_W         = 24,
  parameter int RDY_LOW_WAIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic              clk_i,
  input logic              rst_i,
  dac_spi_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + RDY_LOW_WAIT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;
  state_t            state, state_n;
  logic [N_REQ-1:0]  pend;
  logic [CODE_W-1:0] slot [N_REQ];
  logic [PW-1:0]     rr_ptr, cur, win;
  logic [CW-1:0]     cnt;
  logic              issue, fin, fail;
  // Scanning downward leaves the first pending slot at or after rr_ptr in win.
  always_comb begin
    int j;
    j = 0;
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(rr_ptr) + i) % N_REQ;
`ifdef DAC_ARB_WB_PRIO_EN
      win = (pend[j] && j != 0) ? PW'(j) : win;
`else
      win = pend[j] ? PW'(j) : win;
`endif
    end
`ifdef DAC_ARB_WB_PRIO_EN
    win = pend[0] ? '0 : win;
`endif
  end
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    issue = 1'b0;
    fin = 1'b0;
    fail = 1'b0;
    case (state)
      IDLE: begin
        issue = |pend && bus.spi_rdy;
        state_n = issue ? WAIT_LOW : IDLE;
      end
      WAIT_LOW: begin
        fail = bus.spi_rdy && cnt == CW'(RDY_LOW_WAIT - 1);
        state_n = !bus.spi_rdy ? WAIT_HIGH : fail ? IDLE : WAIT_LOW;
      end
      WAIT_HIGH: begin
        fin = bus.spi_rdy;
        fail = !bus.spi_rdy && cnt == CW'(TIMEOUT_CYCLES - 1);
        state_n = (fin || fail) ? IDLE : WAIT_HIGH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.busy = pend;
    for (int k = 0; k < N_REQ; k++)
      bus.busy[k] = pend[k] | (state != IDLE && cur == PW'(k));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend <= '0;
      rr_ptr <= '0;
      cur <= '0;
      cnt <= '0;
      bus.done <= '0;
      bus.err <= 1'b0;
      bus.spi_wre <= 1'b0;
      bus.spi_data <= '0;
      for (int k = 0; k < N_REQ; k++)
        slot[k] <= '0;
    end else begin
      cnt <= (state == IDLE || state_n != state) ? '0 : cnt + 1'b1;
      bus.spi_wre <= issue;
      bus.done <= (fin || fail) ? N_REQ'(1) << cur : '0;
      bus.err <= fail | (bus.err & ~bus.err_clr);
      if (issue) begin
        bus.spi_data <= DATA_W'(slot[win]);
        cur <= win;
      end
      if (fin)
        rr_ptr <= (cur == PW'(N_REQ - 1)) ? '0 : cur + 1'b1;
      // A fresh strobe beats the grant clear, so a same-cycle rewrite is sent as a later frame.
      for (int k = 0; k < N_REQ; k++) begin
        if (bus.req[k]) begin
          slot[k] <= bus.code[k*CODE_W +: CODE_W];
          pend[k] <= 1'b1;
        end else if (issue && win == PW'(k)) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end
endmodule
